// File: rtl/roc_master.sv
`default_nettype none
// ============================================================================
// Module   : roc_master
// Purpose  : Host-side initiator for the read-once-clear memory bus. Accepts
//            one host command at a time over a valid/ready handshake, runs a
//            single bus cycle for a write or a read-then-capture for a read,
//            and returns read data on a valid/ready response channel. A
//            per-address "fresh" bitmap lets the host tell a first read after
//            a write from a repeat read. Repeat reads are tallied in a
//            saturating counter.
// Ports    : clk                      - rising-edge clock
//            rst                      - asynchronous active-low reset
//            cmd_valid/cmd_ready      - host command handshake
//            cmd_wr/cmd_addr/cmd_data - command fields (data unused on reads)
//            rsp_valid/rsp_ready      - read response handshake
//            rsp_data/rsp_fresh       - captured read word and fresh flag
//            stale_cnt                - saturating count of non-fresh reads
//            mem_wr/mem_addr/mem_data - memory bus outputs
//            mem_rdata                - memory registered read data
// Revision : 1.0 - initial release
// ============================================================================
module roc_master #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int DEP = 16,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_fresh,
  output logic [CW-1:0] stale_cnt,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RD    = 3'd2,
    CAP   = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [CW-1:0] STALE_MAX = {CW{1'b1}};

  state_t         state;
  logic [DEP-1:0] fresh;

  // mem_addr/mem_data double as the latched command fields: they are loaded
  // on accept and parked afterwards, so no separate command register exists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fresh <= 1'b0;
      stale_cnt <= '0;
      fresh     <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            mem_addr  <= cmd_addr;
            if (cmd_wr) begin
              mem_wr   <= 1'b1;
              mem_data <= cmd_data;
              state    <= WRITE;
            end else begin
              state    <= RD;
            end
          end
        end
        WRITE: begin
          mem_wr          <= 1'b0;
          fresh[mem_addr] <= 1'b1;
          cmd_ready       <= 1'b1;
          state           <= IDLE;
        end
        RD: begin
          // Memory registers its read word at the end of this cycle.
          state <= CAP;
        end
        CAP: begin
          rsp_data        <= mem_rdata;
          rsp_fresh       <= fresh[mem_addr];
          fresh[mem_addr] <= 1'b0;
          if (!fresh[mem_addr] && (stale_cnt != STALE_MAX)) begin
            stale_cnt <= stale_cnt + CW'(1);
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          mem_wr    <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roc_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_roc_master
// Purpose  : Directed self-checking bench for roc_master. A main instance uses
//            the default counter width; a second instance with CW=2 receives
//            the same stimulus so counter saturation can be observed.
//            A small registered memory model supplies mem_rdata.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_roc_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_wr;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_ready;
  logic [7:0] mem_rdata;

  logic       cmd_ready, rsp_valid, rsp_fresh, mem_wr;
  logic [7:0] rsp_data, stale_cnt, mem_data;
  logic [3:0] mem_addr;

  logic       s_cmd_ready, s_rsp_valid, s_rsp_fresh, s_mem_wr;
  logic [7:0] s_rsp_data, s_mem_data;
  logic [1:0] s_stale_cnt;
  logic [3:0] s_mem_addr;

  int n_cmp;
  int n_err;

  roc_master #(.DW(8), .AW(4), .DEP(16), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fresh(rsp_fresh), .stale_cnt(stale_cnt),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rdata(mem_rdata)
  );

  roc_master #(.DW(8), .AW(4), .DEP(16), .CW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
    .rsp_fresh(s_rsp_fresh), .stale_cnt(s_stale_cnt),
    .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: writes on mem_wr, registered read of the addressed word.
  // force_zero emulates the word having been cleared by an earlier read.
  logic [7:0] model [16];
  logic       model_clr;
  logic       force_zero;
  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 16; i++) model[i] <= 8'h00;
    end else if (mem_wr) begin
      model[mem_addr] <= mem_data;
    end
    mem_rdata <= force_zero ? 8'h00 : model[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    model_clr  = 1'b1;
    force_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom);
      cmd_wr    = 1'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_data  = 8'($urandom);
      rsp_ready = 1'($urandom);
      step();
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    n_cmp++; if (stale_cnt !== 8'h00) begin n_err++; $display("FAIL reset_stale_cnt: got %h expected 00", stale_cnt); end
    n_cmp++; if ({rsp_data, rsp_fresh, mem_addr, mem_data} !== 21'h0) begin n_err++;
      $display("FAIL reset_regs: got rsp_data=%h rsp_fresh=%b mem_addr=%h mem_data=%h expected all 0", rsp_data, rsp_fresh, mem_addr, mem_data); end
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 4'h0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
    model_clr = 1'b0;
    rst       = 1'b1;
    step();
  endtask

  task automatic test_write();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_before: got %b expected 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_data = 8'hA5;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if ({mem_wr, mem_addr, mem_data} !== {1'b1, 4'd3, 8'hA5}) begin n_err++;
      $display("FAIL wr_bus: got wr=%b addr=%h data=%h expected wr=1 addr=3 data=a5", mem_wr, mem_addr, mem_data); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_busy: got %b expected 0", cmd_ready); end
    step();
    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL wr_one_pulse: got %b expected 0", mem_wr); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_after: got %b expected 1", cmd_ready); end
    n_cmp++; if ({mem_addr, mem_data} !== {4'd3, 8'hA5}) begin n_err++;
      $display("FAIL wr_parked: got addr=%h data=%h expected addr=3 data=a5", mem_addr, mem_data); end
  endtask

  task automatic test_fresh_read();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3; cmd_data = 8'h5A;
    step();
    cmd_valid = 1'b0;
    n_cmp++; if ({mem_wr, mem_addr, mem_data, rsp_valid} !== {1'b0, 4'd3, 8'hA5, 1'b0}) begin n_err++;
      $display("FAIL rd_bus: got wr=%b addr=%h data=%h rsp_valid=%b expected wr=0 addr=3 data=a5 rsp_valid=0", mem_wr, mem_addr, mem_data, rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_valid: got %b expected 0", rsp_valid); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_latency: got %b expected 1", rsp_valid); end
    n_cmp++; if ({rsp_data, rsp_fresh} !== {8'hA5, 1'b1}) begin n_err++;
      $display("FAIL rd_fresh_data: got data=%h fresh=%b expected data=a5 fresh=1", rsp_data, rsp_fresh); end
    n_cmp++; if (stale_cnt !== 8'd0) begin n_err++; $display("FAIL rd_fresh_stale: got %0d expected 0", stale_cnt); end
    step();
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++;
      $display("FAIL rd_handshake: got rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_repeat_read();
    force_zero = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    n_cmp++; if ({rsp_valid, rsp_data, rsp_fresh} !== {1'b1, 8'h00, 1'b0}) begin n_err++;
      $display("FAIL rep_rsp: got valid=%b data=%h fresh=%b expected 1/00/0", rsp_valid, rsp_data, rsp_fresh); end
    n_cmp++; if (stale_cnt !== 8'd1) begin n_err++; $display("FAIL rep_stale: got %0d expected 1", stale_cnt); end
    step();
    force_zero = 1'b0;
  endtask

  task automatic test_backpressure();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd7; cmd_data = 8'h3C;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd7;
    rsp_ready = 1'b0;
    step();
    // Keep a pending write on the command port; it must not be taken.
    cmd_wr = 1'b1; cmd_addr = 4'd1; cmd_data = 8'hFF;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rsp_valid, rsp_data, rsp_fresh, cmd_ready, mem_wr} !== {1'b1, 8'h3C, 1'b1, 1'b0, 1'b0}) begin n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h fresh=%b ready=%b mem_wr=%b expected 1/3c/1/0/0",
                 i, rsp_valid, rsp_data, rsp_fresh, cmd_ready, mem_wr); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    n_cmp++; if ({rsp_valid, cmd_ready, mem_wr} !== 3'b010) begin n_err++;
      $display("FAIL bp_release: got valid=%b ready=%b mem_wr=%b expected 0/1/0", rsp_valid, cmd_ready, mem_wr); end
    step();
    n_cmp++; if ({mem_wr, mem_addr, mem_data, cmd_ready} !== {1'b1, 4'd1, 8'hFF, 1'b0}) begin n_err++;
      $display("FAIL bp_accept: got wr=%b addr=%h data=%h ready=%b expected 1/1/ff/0", mem_wr, mem_addr, mem_data, cmd_ready); end
    cmd_valid = 1'b0;
    step();
    n_cmp++; if (stale_cnt !== 8'd1) begin n_err++; $display("FAIL bp_stale: got %0d expected 1", stale_cnt); end
  endtask

  task automatic test_saturation();
    force_zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      n_cmp++; if ({rsp_valid, rsp_fresh} !== 2'b10) begin n_err++;
        $display("FAIL sat_rsp[%0d]: got valid=%b fresh=%b expected 1/0", i, rsp_valid, rsp_fresh); end
      step();
    end
    n_cmp++; if (s_stale_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cw2: got %0d expected 3", s_stale_cnt); end
    n_cmp++; if (stale_cnt !== 8'd6) begin n_err++; $display("FAIL sat_cw8: got %0d expected 6", stale_cnt); end
    force_zero = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_data = 8'h77;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    // DUT is now in CAP; reset asynchronously mid-cycle.
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({cmd_ready, rsp_valid, stale_cnt} !== {1'b1, 1'b0, 8'd0}) begin n_err++;
      $display("FAIL rst_async: got ready=%b valid=%b stale=%0d expected 1/0/0", cmd_ready, rsp_valid, stale_cnt); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
      step();
    end
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd3;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    n_cmp++; if ({rsp_valid, rsp_data, rsp_fresh} !== {1'b1, 8'h77, 1'b0}) begin n_err++;
      $display("FAIL rst_next_read: got valid=%b data=%h fresh=%b expected 1/77/0", rsp_valid, rsp_data, rsp_fresh); end
    n_cmp++; if (stale_cnt !== 8'd1) begin n_err++; $display("FAIL rst_next_stale: got %0d expected 1", stale_cnt); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write();
    test_fresh_read();
    test_repeat_read();
    test_backpressure();
    test_saturation();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
